// File: rtl/cdc_gray_fifo.sv
// Dual-clock FIFO: Gray-coded pointers cross domains through multi-flop
// synchronisers; each side reports a conservative fill level and sticky errors.
module cdc_gray_fifo #(
  parameter int DataWidth         = 32,
  parameter int AddrWidth         = 4,
  parameter int SyncStages        = 2,
  parameter int AlmostFullThresh  = (2 ** AddrWidth) - 1,
  parameter int AlmostEmptyThresh = 1
) (
  input  logic                 clk_DA,
  input  logic                 rst,
  input  logic                 clk_DB,
  input  logic                 Push_DA,
  input  logic [DataWidth-1:0] DataIn_DA,
  output logic                 FifoFull_DA,
  output logic                 AlmostFull_DA,
  output logic [AddrWidth:0]   Level_DA,
  output logic                 Overflow_DA,
  input  logic                 Deq_DB,
  output logic                 DataValid_DB,
  output logic [DataWidth-1:0] DataOut_DB,
  output logic                 AlmostEmpty_DB,
  output logic [AddrWidth:0]   Level_DB,
  output logic                 Underflow_DB
);

  localparam int Depth = 2 ** AddrWidth;
  localparam int PW    = AddrWidth + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t DepthP = ptr_t'(Depth);
  localparam ptr_t AfTh   = ptr_t'(AlmostFullThresh);
  localparam ptr_t AeTh   = ptr_t'(AlmostEmptyThresh);

  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DataWidth-1:0] mem_q [Depth];

  // A domain
  ptr_t head_bin_q, head_bin_d;
  ptr_t head_gray_q, head_gray_d;
  ptr_t tail_sync_q [SyncStages];
  ptr_t tail_sync_d [SyncStages];
  logic overflow_q, overflow_d;
  ptr_t tail_bin_sync, level_da;
  logic full_da, push_ok;

  // B domain
  ptr_t tail_bin_q, tail_bin_d;
  ptr_t tail_gray_q, tail_gray_d;
  ptr_t head_sync_q [SyncStages];
  ptr_t head_sync_d [SyncStages];
  logic valid_q, valid_d;
  logic [DataWidth-1:0] dout_q, dout_d;
  logic underflow_q, underflow_d;
  ptr_t head_bin_sync, level_db;
  logic empty_db, load_db;

  always_comb begin
    tail_bin_sync = gray2bin(tail_sync_q[SyncStages-1]);
    level_da      = head_bin_q - tail_bin_sync;
    full_da       = (level_da == DepthP);
    push_ok       = Push_DA & ~full_da;
    head_bin_d    = head_bin_q + ptr_t'(push_ok);
    head_gray_d   = bin2gray(head_bin_d);
    overflow_d    = overflow_q | (Push_DA & full_da);
    tail_sync_d[0] = tail_gray_q;
    for (int i = 1; i < SyncStages; i++) begin
      tail_sync_d[i] = tail_sync_q[i-1];
    end
  end

  always_ff @(posedge clk_DA or posedge rst) begin
    if (rst) begin
      head_bin_q  <= '0;
      head_gray_q <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < SyncStages; i++) begin
        tail_sync_q[i] <= '0;
      end
    end else begin
      head_bin_q  <= head_bin_d;
      head_gray_q <= head_gray_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < SyncStages; i++) begin
        tail_sync_q[i] <= tail_sync_d[i];
      end
    end
  end

  // Storage is written only from A; the lagging tail keeps B's slot safe.
  always_ff @(posedge clk_DA) begin
    if (push_ok) begin
      mem_q[head_bin_q[AddrWidth-1:0]] <= DataIn_DA;
    end
  end

  always_comb begin
    head_bin_sync = gray2bin(head_sync_q[SyncStages-1]);
    level_db      = head_bin_sync - tail_bin_q;
    empty_db      = (level_db == '0);
    load_db       = ~empty_db & (~valid_q | Deq_DB);
    tail_bin_d    = tail_bin_q + ptr_t'(load_db);
    tail_gray_d   = bin2gray(tail_bin_d);
    dout_d        = load_db ? mem_q[tail_bin_q[AddrWidth-1:0]] : dout_q;
    valid_d       = load_db | (valid_q & ~Deq_DB);
    underflow_d   = underflow_q | (Deq_DB & ~valid_q);
    head_sync_d[0] = head_gray_q;
    for (int i = 1; i < SyncStages; i++) begin
      head_sync_d[i] = head_sync_q[i-1];
    end
  end

  always_ff @(posedge clk_DB or posedge rst) begin
    if (rst) begin
      tail_bin_q  <= '0;
      tail_gray_q <= '0;
      valid_q     <= 1'b0;
      dout_q      <= '0;
      underflow_q <= 1'b0;
      for (int i = 0; i < SyncStages; i++) begin
        head_sync_q[i] <= '0;
      end
    end else begin
      tail_bin_q  <= tail_bin_d;
      tail_gray_q <= tail_gray_d;
      valid_q     <= valid_d;
      dout_q      <= dout_d;
      underflow_q <= underflow_d;
      for (int i = 0; i < SyncStages; i++) begin
        head_sync_q[i] <= head_sync_d[i];
      end
    end
  end

  assign FifoFull_DA    = full_da;
  assign AlmostFull_DA  = (level_da >= AfTh);
  assign Level_DA       = level_da;
  assign Overflow_DA    = overflow_q;
  assign DataValid_DB   = valid_q;
  assign DataOut_DB     = dout_q;
  assign AlmostEmpty_DB = (level_db <= AeTh);
  assign Level_DB       = level_db;
  assign Underflow_DB   = underflow_q;

endmodule
